// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one memory port between the CPU controller and the host loader/debug
// port. The two requesters take turns (round-robin). Each granted access
// latches its command, runs for LATENCY cycles, and then gives the winner a
// one-cycle ack.
//
// Ports:
//   clock, reset          system clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata  CPU request; req is held until cpu_ack
//   cpu_ack, cpu_rdata     CPU completion pulse and registered read data
//   host_req/we/addr/wdata host request; req is held until host_ack
//   host_ack, host_rdata   host completion pulse and registered read data
//   mem_addr/wdata/we      memory command; we is high for the first ACCESS cycle only
//   mem_rdata              memory read data, valid LATENCY cycles after the address
//   busy                   high whenever the FSM is not IDLE
//   owner                  current or last grant (0 = CPU, 1 = host)
module memory_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t      state;
  logic  [3:0] cnt;
  logic        we_q;
  logic        any_req;
  logic        win;

  // When both requesters ask, the grant goes to the one that is not the last
  // owner. When only one asks, it wins.
  always_comb begin
    any_req = cpu_req | host_req;
    if (cpu_req && host_req) win = ~owner;
    else                     win = host_req;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      cpu_ack    <= 1'b0;
      host_ack   <= 1'b0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      owner      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            owner     <= win;
            cnt       <= LAT;
            we_q      <= win ? host_we    : cpu_we;
            mem_we    <= win ? host_we    : cpu_we;
            mem_addr  <= win ? host_addr  : cpu_addr;
            mem_wdata <= win ? host_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          cnt    <= cnt - 4'd1;
          // Read data is captured on the same edge that raises ack, so the
          // rdata register is already valid during the ack cycle.
          if (cnt == 4'd1) begin
            state <= RESP;
            if (owner) host_ack <= 1'b1;
            else       cpu_ack  <= 1'b1;
            if (!we_q) begin
              if (owner) host_rdata <= mem_rdata;
              else       cpu_rdata  <= mem_rdata;
            end
          end
        end
        RESP: begin
          cpu_ack  <= 1'b0;
          host_ack <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Directed bench for memory_arbiter. It builds three instances with LATENCY of
// 2, 4 and 1. Each instance has its own small memory model. Every expected
// value below is worked out by hand from the arbiter timing: a request
// sampled at edge E0 gives ACCESS for E0..E0+L and an ack cycle at E0+L.
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        cpu_req    [3];
  logic        cpu_we     [3];
  logic [15:0] cpu_addr   [3];
  logic [15:0] cpu_wdata  [3];
  logic        cpu_ack    [3];
  logic [15:0] cpu_rdata  [3];
  logic        host_req   [3];
  logic        host_we    [3];
  logic [15:0] host_addr  [3];
  logic [15:0] host_wdata [3];
  logic        host_ack   [3];
  logic [15:0] host_rdata [3];
  logic [15:0] mem_addr   [3];
  logic [15:0] mem_wdata  [3];
  logic        mem_we     [3];
  logic [15:0] mem_rdata  [3];
  logic        busy       [3];
  logic        owner      [3];

  logic [2:0]  ld_en = '0;
  logic [7:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
    logic [15:0] mem [256];

    always @(posedge clock) begin
      if (ld_en[g])        mem[ld_addr] <= ld_data;
      else if (mem_we[g])  mem[mem_addr[g][7:0]] <= mem_wdata[g];
    end

    assign mem_rdata[g] = mem[mem_addr[g][7:0]];

    memory_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(L)) u_dut (
      .clock      (clock),
      .reset      (reset),
      .cpu_req    (cpu_req[g]),
      .cpu_we     (cpu_we[g]),
      .cpu_addr   (cpu_addr[g]),
      .cpu_wdata  (cpu_wdata[g]),
      .cpu_ack    (cpu_ack[g]),
      .cpu_rdata  (cpu_rdata[g]),
      .host_req   (host_req[g]),
      .host_we    (host_we[g]),
      .host_addr  (host_addr[g]),
      .host_wdata (host_wdata[g]),
      .host_ack   (host_ack[g]),
      .host_rdata (host_rdata[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_we     (mem_we[g]),
      .mem_rdata  (mem_rdata[g]),
      .busy       (busy[g]),
      .owner      (owner[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cpu_req[i] = 1'b0;  cpu_we[i] = 1'b0;  cpu_addr[i] = '0;  cpu_wdata[i] = '0;
      host_req[i] = 1'b0; host_we[i] = 1'b0; host_addr[i] = '0; host_wdata[i] = '0;
    end

    // Preload the memory models while reset is held.
    ld_en = 3'b001; ld_addr = 8'h10; ld_data = 16'hBEEF; step();
    ld_addr = 8'h30; ld_data = 16'hDEAD;                  step();
    ld_en = 3'b100; ld_addr = 8'h50; ld_data = 16'hA5A5;  step();
    ld_en = 3'b000;

    // Reset state
    chk("rst_busy",   busy[0],      0);
    chk("rst_owner",  owner[0],     1);
    chk("rst_cpuack", cpu_ack[0],   0);
    chk("rst_hstack", host_ack[0],  0);
    chk("rst_memwe",  mem_we[0],    0);
    chk("rst_maddr",  mem_addr[0],  0);
    chk("rst_crdata", cpu_rdata[0], 0);
    chk("rst_hrdata", host_rdata[0], 0);
    reset = 1'b0;
    step();

    // 1: CPU read of 0x0010, L=2
    cpu_addr[0] = 16'h0010; cpu_we[0] = 1'b0; cpu_req[0] = 1'b1;
    step(); // E0
    chk("t1_busy",   busy[0],     1);
    chk("t1_owner",  owner[0],    0);
    chk("t1_maddr0", mem_addr[0], 16'h0010);
    chk("t1_memwe",  mem_we[0],   0);
    chk("t1_ack0",   cpu_ack[0],  0);
    step(); // E1
    chk("t1_maddr1", mem_addr[0], 16'h0010);
    chk("t1_ack1",   cpu_ack[0],  0);
    step(); // E2
    chk("t1_ack2",   cpu_ack[0],  1);
    chk("t1_hack",   host_ack[0], 0);
    chk("t1_rdata",  cpu_rdata[0], 16'hBEEF);
    cpu_req[0] = 1'b0;
    step(); // E3
    chk("t1_ack3",   cpu_ack[0],  0);
    chk("t1_idle",   busy[0],     0);

    // 2: host write 0x0020 <= 0x1234
    host_addr[0] = 16'h0020; host_wdata[0] = 16'h1234; host_we[0] = 1'b1; host_req[0] = 1'b1;
    step(); // E0
    chk("t2_memwe0", mem_we[0],    1);
    chk("t2_maddr",  mem_addr[0],  16'h0020);
    chk("t2_mwdata", mem_wdata[0], 16'h1234);
    chk("t2_owner",  owner[0],     1);
    step(); // E1
    chk("t2_memwe1", mem_we[0],    0);
    chk("t2_hack1",  host_ack[0],  0);
    step(); // E2
    chk("t2_hack2",  host_ack[0],  1);
    chk("t2_cack2",  cpu_ack[0],   0);
    chk("t2_hrdata", host_rdata[0], 0);
    chk("t2_memwe2", mem_we[0],    0);
    host_req[0] = 1'b0; host_we[0] = 1'b0;
    step(); // E3
    chk("t2_hack3",  host_ack[0],  0);
    chk("t2_hold_wd", mem_wdata[0], 16'h1234);
    cpu_addr[0] = 16'h0020; cpu_req[0] = 1'b1;
    step(); step(); step(); // E0..E2 of the read-back
    chk("t2_rb_ack",   cpu_ack[0],   1);
    chk("t2_rb_rdata", cpu_rdata[0], 16'h1234);
    cpu_req[0] = 1'b0;
    step();

    // 4: address change after grant is ignored
    cpu_addr[0] = 16'h0010; cpu_req[0] = 1'b1;
    step(); // E0
    cpu_addr[0] = 16'h0030;
    step(); // E1
    chk("t4_maddr",  mem_addr[0], 16'h0010);
    step(); // E2
    chk("t4_ack",    cpu_ack[0],   1);
    chk("t4_rdata",  cpu_rdata[0], 16'hBEEF);
    cpu_req[0] = 1'b0;
    step();

    // 3: continuous contention after reset alternates CPU, host, CPU, host
    reset = 1'b1;
    #1;
    chk("t3_rst_owner", owner[0], 1);
    step();
    reset = 1'b0;
    step();
    chk("t3_rst_crd", cpu_rdata[0], 0);
    cpu_addr[0] = 16'h0010;  cpu_we[0] = 1'b0;
    host_addr[0] = 16'h0020; host_we[0] = 1'b0;
    cpu_req[0] = 1'b1; host_req[0] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("t3_cack_k%0d", k), cpu_ack[0],  ((k % 4 == 2) && ((k / 4) % 2 == 0)) ? 1 : 0);
      chk($sformatf("t3_hack_k%0d", k), host_ack[0], ((k % 4 == 2) && ((k / 4) % 2 == 1)) ? 1 : 0);
      if (k % 4 == 0)
        chk($sformatf("t3_owner_k%0d", k), owner[0], (k / 4) % 2);
    end
    cpu_req[0] = 1'b0; host_req[0] = 1'b0;
    chk("t3_crdata", cpu_rdata[0],  16'hBEEF);
    chk("t3_hrdata", host_rdata[0], 16'h1234);
    step(); step();

    // 5: L=4, reset during the second ACCESS cycle of a host write
    host_addr[1] = 16'h0040; host_wdata[1] = 16'h5555; host_we[1] = 1'b1; host_req[1] = 1'b1;
    step(); // E0
    chk("t5_memwe0", mem_we[1], 1);
    chk("t5_owner0", owner[1],  1);
    step(); // E1: second ACCESS cycle
    chk("t5_busy1",  busy[1],   1);
    #3 reset = 1'b1;
    #1;
    chk("t5_busy_r",  busy[1],     0);
    chk("t5_memwe_r", mem_we[1],   0);
    chk("t5_hack_r",  host_ack[1], 0);
    chk("t5_owner_r", owner[1],    1);
    chk("t5_maddr_r", mem_addr[1], 0);
    host_req[1] = 1'b0; host_we[1] = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("t5_nohack_k%0d", k), host_ack[1], 0);
    end
    cpu_addr[1] = 16'h0000; host_addr[1] = 16'h0000;
    cpu_req[1] = 1'b1; host_req[1] = 1'b1;
    step(); // E0
    chk("t5_grant_cpu", owner[1], 0);
    chk("t5_busy2",     busy[1],  1);
    cpu_req[1] = 1'b0; host_req[1] = 1'b0;
    step(); step(); step(); // E1..E3
    chk("t5_ack_e3", cpu_ack[1], 0);
    step(); // E4
    chk("t5_ack_e4",  cpu_ack[1],  1);
    chk("t5_hack_e4", host_ack[1], 0);
    step(); // E5
    chk("t5_idle", busy[1], 0);

    // 6: L=1, back-to-back CPU reads, one access every 3 cycles
    begin
      logic prev;
      prev = 1'b0;
      cpu_addr[2] = 16'h0050; cpu_we[2] = 1'b0; cpu_req[2] = 1'b1;
      for (int k = 0; k < 9; k++) begin
        step();
        chk($sformatf("t6_ack_k%0d", k), cpu_ack[2], (k % 3 == 1) ? 1 : 0);
        chk($sformatf("t6_noconsec_k%0d", k), prev & cpu_ack[2], 0);
        if (k % 3 == 1)
          chk($sformatf("t6_rdata_k%0d", k), cpu_rdata[2], 16'hA5A5);
        prev = cpu_ack[2];
      end
      cpu_req[2] = 1'b0;
      step(); step();
      chk("t6_idle", busy[2], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
